// File: rtl/yarvi_trace_buf.sv
// yarvi_trace_buf: commit-stream trace buffer.
//
// Captures each retired instruction from the core's ME stage into a FIFO and
// serializes it as a byte packet on a valid/ready stream (UART or debug link).
// freeze backpressures the core before the FIFO fills; records that arrive
// while the FIFO is full and nothing pops are dropped and counted.
//
// Packet (PKT = 5 + XW/4 bytes), sent byte 0 first:
//   {priv, 1'b0, rd}, pc (LE, XW/8 B), insn (LE, 4 B), wb_val (LE, XW/8 B)
//
// Ports:
//   clock, reset        core clock; synchronous active-high reset
//   enable              capture enable (does not stop draining)
//   me_*                commit record from the core
//   freeze              registered stall request to the core
//   tx_valid/tx_data/tx_ready  byte stream out
//   overflow            sticky drop flag
//   drop_count          saturating count of dropped records
module yarvi_trace_buf #(
    parameter int XW    = 64,
    parameter int DEPTH = 16,
    parameter int SLACK = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          me_valid,
    input  logic [1:0]    me_priv,
    input  logic [XW-1:0] me_pc,
    input  logic [31:0]   me_insn,
    input  logic [4:0]    me_wb_rd,
    input  logic [XW-1:0] me_wb_val,
    output logic          freeze,
    output logic          tx_valid,
    output logic [7:0]    tx_data,
    input  logic          tx_ready,
    output logic          overflow,
    output logic [15:0]   drop_count
);

    localparam int PKT = 5 + XW / 4;
    localparam int PW  = 8 * PKT;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int IW  = $clog2(PKT);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    typedef struct packed {
        logic [1:0]    priv;
        logic [4:0]    rd;
        logic [31:0]   insn;
        logic [XW-1:0] pc;
        logic [XW-1:0] wb_val;
    } rec_t;

    rec_t          mem [DEPTH];
    rec_t          wr_rec;
    rec_t          head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic [0:0]    state;
    logic [IW-1:0] idx;
    logic [PW-1:0] sr;
    logic [PW-1:0] pkt_load;
    logic          push_req, push, pop, last;

    assign wr_rec   = '{priv: me_priv, rd: me_wb_rd, insn: me_insn, pc: me_pc, wb_val: me_wb_val};
    assign head     = mem[rd_ptr];
    // Header sits in the low byte so the shift register emits it first.
    assign pkt_load = {head.wb_val, head.insn, head.pc, head.priv, 1'b0, head.rd};

    assign push_req = enable & me_valid;
    assign last     = (state == S_SEND) && tx_ready && (idx == IW'(PKT - 1));
    // The only pop is the move into the shift register: from IDLE, or on
    // the final byte of a packet so consecutive packets have no bubble.
    assign pop      = (count != '0) && ((state == S_IDLE) || last);
    // A full FIFO still accepts when the head leaves in the same cycle; the
    // head is read combinationally before the slot is overwritten.
    assign push     = push_req && ((count != CW'(DEPTH)) || pop);

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CW'(1);
        else if (pop && !push)
            count_next = count - CW'(1);
    end

    assign tx_valid = (state == S_SEND);
    assign tx_data  = sr[7:0];

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= wr_rec;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            freeze     <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
            state      <= S_IDLE;
            idx        <= '0;
            sr         <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count  <= count_next;
            freeze <= (count_next >= CW'(DEPTH - SLACK));

            if (push_req && !push) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF)
                    drop_count <= drop_count + 16'd1;
            end

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        sr    <= pkt_load;
                        idx   <= '0;
                        state <= S_SEND;
                    end
                end
                default: begin
                    if (tx_ready) begin
                        if (last) begin
                            if (pop) begin
                                sr  <= pkt_load;
                                idx <= '0;
                            end else begin
                                // Fully shifted out, so tx_data idles at 0.
                                sr    <= sr >> 8;
                                state <= S_IDLE;
                            end
                        end else begin
                            sr  <= sr >> 8;
                            idx <= idx + IW'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_yarvi_trace_buf.sv
module tb_yarvi_trace_buf;

    localparam int XW    = 64;
    localparam int DEPTH = 16;
    localparam int SLACK = 2;
    localparam int PKT   = 5 + XW / 4;

    typedef struct {
        logic [1:0]    priv;
        logic [4:0]    rd;
        logic [31:0]   insn;
        logic [XW-1:0] pc;
        logic [XW-1:0] val;
    } rec_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          me_valid = 1'b0;
    logic          tx_ready = 1'b0;
    rec_t          cur;
    logic          freeze, tx_valid, overflow;
    logic [7:0]    tx_data;
    logic [15:0]   drop_count;

    yarvi_trace_buf #(.XW(XW), .DEPTH(DEPTH), .SLACK(SLACK)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .me_valid   (me_valid),
        .me_priv    (cur.priv),
        .me_pc      (cur.pc),
        .me_insn    (cur.insn),
        .me_wb_rd   (cur.rd),
        .me_wb_val  (cur.val),
        .freeze     (freeze),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: records waiting, bytes of the packet on the wire,
    // and the full expected byte stream in push order.
    rec_t       m_fifo[$];
    logic [7:0] m_pkt[$];
    bit         m_sending;
    bit         m_ovf;
    bit         m_freeze;
    int         m_drops;
    logic [7:0] exp_bytes[$];
    logic [7:0] got_bytes[$];

    function automatic logic [7:0] pkt_byte(input rec_t r, input int i);
        if (i == 0)            return {r.priv, 1'b0, r.rd};
        if (i <= XW / 8)       return 8'(r.pc >> (8 * (i - 1)));
        if (i <= XW / 8 + 4)   return 8'(r.insn >> (8 * (i - 1 - XW / 8)));
        return 8'(r.val >> (8 * (i - 5 - XW / 8)));
    endfunction

    function automatic rec_t rand_rec();
        rec_t r;
        r.priv = 2'($urandom());
        r.rd   = 5'($urandom());
        r.insn = $urandom();
        r.pc   = XW'({$urandom(), $urandom()});
        r.val  = XW'({$urandom(), $urandom()});
        return r;
    endfunction

    task automatic step();
        bit   pop, pr, acc;
        rec_t r;
        if (tx_valid && tx_ready && !reset) begin
            got_bytes.push_back(tx_data);
            if (exp_bytes.size() == 0)
                chk("spurious_byte", 1, 0);
            else
                chk("byte_order", tx_data, exp_bytes.pop_front());
        end
        @(posedge clock);
        if (reset) begin
            m_fifo.delete();
            m_pkt.delete();
            exp_bytes.delete();
            m_sending = 0;
            m_ovf     = 0;
            m_drops   = 0;
            m_freeze  = 0;
        end else begin
            pop = (m_fifo.size() > 0) && (!m_sending || (tx_ready && m_pkt.size() == 1));
            pr  = enable && me_valid;
            acc = pr && ((m_fifo.size() < DEPTH) || pop);
            if (m_sending && tx_ready)
                void'(m_pkt.pop_front());
            if (pop) begin
                r = m_fifo.pop_front();
                m_pkt.delete();
                for (int i = 0; i < PKT; i++) m_pkt.push_back(pkt_byte(r, i));
                m_sending = 1;
            end else if (m_pkt.size() == 0) begin
                m_sending = 0;
            end
            if (acc) begin
                m_fifo.push_back(cur);
                for (int i = 0; i < PKT; i++) exp_bytes.push_back(pkt_byte(cur, i));
            end else if (pr) begin
                m_ovf = 1;
                if (m_drops < 65535) m_drops++;
            end
            m_freeze = (m_fifo.size() >= DEPTH - SLACK);
        end
        #1;
        chk("tx_valid", tx_valid, m_sending);
        if (m_sending) chk("tx_data", tx_data, m_pkt[0]);
        chk("freeze", freeze, m_freeze);
        chk("overflow", overflow, m_ovf);
        chk("drop_count", drop_count, 64'(m_drops));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        me_valid = 1'b0;
        step();
        reset = 1'b0;
        got_bytes.delete();
    endtask

    // mode 0: ready held high; 1: random ready; 2: ready pattern 1,0,0,1
    task automatic drain(input int mode);
        int budget = 2000;
        int c = 0;
        me_valid = 1'b0;
        while ((m_fifo.size() > 0 || m_sending) && budget > 0) begin
            case (mode)
                0: tx_ready = 1'b1;
                1: tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = (c % 4 == 0) || (c % 4 == 3);
            endcase
            step();
            c++;
            budget--;
        end
        chk("drain_timeout", (m_fifo.size() > 0 || m_sending), 0);
        chk("drain_left", exp_bytes.size(), 0);
        tx_ready = 1'b1;
        step();
    endtask

    logic [7:0] lit [PKT] = '{8'hC1, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00,
                              8'h93, 8'h00, 8'h50, 8'h00,
                              8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    task automatic check_literal(input string tag);
        chk({tag, "_len"}, got_bytes.size(), PKT);
        for (int i = 0; i < PKT && i < got_bytes.size(); i++)
            chk(tag, got_bytes[i], lit[i]);
    endtask

    initial begin
        rec_t fixed;
        int   budget;
        fixed.priv = 2'd3;
        fixed.pc   = 64'h8000_0000;
        fixed.insn = 32'h0050_0093;
        fixed.rd   = 5'd1;
        fixed.val  = 64'd5;
        cur = fixed;

        // Reset state
        do_reset();
        chk("reset_tx_data", tx_data, 8'h00);
        chk("reset_tx_valid", tx_valid, 0);

        // Single record, ready held high
        enable = 1'b1;
        tx_ready = 1'b1;
        cur = fixed;
        me_valid = 1'b1;
        step();
        drain(0);
        check_literal("single_byte");

        // Backpressure 1,0,0,1
        got_bytes.delete();
        cur = fixed;
        me_valid = 1'b1;
        tx_ready = 1'b1;
        step();
        drain(2);
        check_literal("bp_byte");

        // Fill and freeze
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cur = rand_rec();
            me_valid = 1'b1;
            step();
        end
        chk("fill_freeze_high", freeze, 1);
        drain(0);
        chk("fill_freeze_low", freeze, 0);

        // Overflow: 17 fit (one in the shift register, 16 queued)
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cur = rand_rec();
            me_valid = 1'b1;
            step();
        end
        chk("ovf_flag", overflow, 1);
        chk("ovf_drops", drop_count, 3);
        drain(1);
        chk("ovf_sticky", overflow, 1);

        // Enable gating
        do_reset();
        enable = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cur = rand_rec();
            me_valid = (i % 2 == 0);
            step();
        end
        chk("gate_tx_valid", tx_valid, 0);
        chk("gate_freeze", freeze, 0);

        // Randomized traffic, with rd=0 records mixed in
        enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            cur = rand_rec();
            if ($urandom_range(0, 7) == 0) cur.rd = 5'd0;
            enable   = ($urandom_range(0, 9) != 0);
            me_valid = 1'($urandom_range(0, 1));
            tx_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain(1);

        // Reset mid-packet with 3 records queued
        do_reset();
        enable = 1'b1;
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cur = rand_rec();
            me_valid = 1'b1;
            step();
        end
        me_valid = 1'b0;
        chk("mid_queued", m_fifo.size(), 3);
        got_bytes.delete();
        tx_ready = 1'b1;
        budget = 100;
        while (got_bytes.size() < 7 && budget > 0) begin
            step();
            budget--;
        end
        chk("mid_reach_byte7", got_bytes.size(), 7);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_tx_valid", tx_valid, 0);
        chk("mid_freeze", freeze, 0);
        chk("mid_overflow", overflow, 0);
        chk("mid_drops", drop_count, 0);
        for (int i = 0; i < 30; i++) step();
        chk("mid_quiet", tx_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
